// File: rtl/uart_tx.sv
// 8N1 UART transmitter with CTS# flow control and a one-entry holding register.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx #(
  parameter int unsigned CLK_FREQ = 12000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  input  logic       cts_n,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e          state_q;
  logic [7:0]      hold_q;
  logic            hold_full_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_idx_q;
  logic [CntW-1:0] cnt_q;
  logic            tx_q;
  logic            busy_q;
  logic            cts_meta_q;
  logic            cts_sync_q;
`ifdef UART_TX_PARITY_EN
  logic            parity_q;
`endif

  logic cts_ok;
  logic accept;
  logic cnt_done;
  logic start_ok;
  logic load_frame;

  assign cts_ok   = ~cts_sync_q;
  assign accept   = valid & ~hold_full_q;
  assign cnt_done = (cnt_q == '0);
  assign start_ok = hold_full_q & cts_ok;
  // A pending byte starts either from idle or straight out of the last stop cycle.
  assign load_frame = start_ok & ((state_q == StIdle) | ((state_q == StStop) & cnt_done));

  assign ready = ~hold_full_q;
  assign tx    = tx_q;
  assign busy  = busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      cnt_q       <= CntMax;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      cts_meta_q  <= 1'b1;
      cts_sync_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      cts_meta_q <= cts_n;
      cts_sync_q <= cts_meta_q;

      if (accept) begin
        hold_q      <= data_in;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        StIdle: ;
        StStart: begin
          if (cnt_done) begin
            state_q   <= StData;
            tx_q      <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= 3'd0;
            cnt_q     <= CntMax;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StData: begin
          if (cnt_done) begin
            cnt_q <= CntMax;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= StParity;
              tx_q    <= parity_q;
`else
              state_q <= StStop;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (cnt_done) begin
            state_q <= StStop;
            tx_q    <= 1'b1;
            cnt_q   <= CntMax;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
`endif
        StStop: begin
          if (cnt_done) begin
            if (!start_ok) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
        end
      endcase

      // Overrides the per-state updates above; accept and unload never coincide
      // because accept needs the holding register empty.
      if (load_frame) begin
        state_q     <= StStart;
        shift_q     <= hold_q;
        hold_full_q <= 1'b0;
        cnt_q       <= CntMax;
        tx_q        <= 1'b0;
        busy_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_q    <= ^hold_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus random traffic compared
// cycle by cycle against a frame-level line model.
`timescale 1ns / 1ps
module tb_uart_tx;

  localparam int unsigned ClkFreq = 12000000;
  localparam int unsigned Baud    = 115200;
  localparam int unsigned Cpb     = ClkFreq / Baud;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FrameBits = 11;
`else
  localparam int unsigned FrameBits = 10;
`endif
  localparam int unsigned FrameClks = FrameBits * Cpb;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid = 1'b0;
  logic       cts_n = 1'b1;
  logic       ready;
  logic       tx;
  logic       busy;

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_FREQ(ClkFreq),
    .BAUD    (Baud)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .data_in(data_in),
    .valid  (valid),
    .ready  (ready),
    .cts_n  (cts_n),
    .tx     (tx),
    .busy   (busy)
  );

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;

  // Line model: queue of expected per-clock line levels for the frame in flight.
  bit         m_line[$];
  logic [7:0] m_hold;
  bit         m_full;
  bit         m_cts_meta;
  bit         m_cts_sync;
  bit         exp_tx;
  bit         exp_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_frame(input logic [7:0] b);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[k]) for (int c = 0; c < int'(Cpb); c++) m_line.push_back(bits[k]);
  endfunction

  task automatic model_reset();
    m_line.delete();
    m_full     = 1'b0;
    m_hold     = 8'h00;
    m_cts_meta = 1'b1;
    m_cts_sync = 1'b1;
    exp_tx     = 1'b1;
    exp_busy   = 1'b0;
  endtask

  task automatic model_edge();
    bit full_old;
    bit cts_ok;
    full_old = m_full;
    cts_ok   = !m_cts_sync;
    if (m_line.size() != 0) begin
      exp_tx   = m_line.pop_front();
      exp_busy = 1'b1;
    end else if (m_full && cts_ok) begin
      push_frame(m_hold);
      m_full   = 1'b0;
      exp_tx   = m_line.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
    if (valid && !full_old) begin
      m_hold = data_in;
      m_full = 1'b1;
    end
    m_cts_sync = m_cts_meta;
    m_cts_meta = cts_n;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    check("tx", 32'(tx), 32'(exp_tx));
    check("ready", 32'(ready), 32'(!m_full));
    check("busy", 32'(busy), 32'(exp_busy));
    if (busy === 1'b1) busy_cycles++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    data_in = b;
    valid   = 1'b1;
    tick();
    valid   = 1'b0;
    data_in = 8'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b0;
    int lat;
    bit seen;

    // Asynchronous reset before any clock edge.
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    run(3);
    reset_n = 1'b1;
    run(2);

    // Single byte; tx falls one clock after acceptance.
    cts_n = 1'b0;
    run(3);
    b0 = busy_cycles;
    send(8'hA5);
    tick();
    check("a5_start", 32'(tx), 32'd0);
    run(FrameClks + 10);
    check("a5_busy_len", 32'(busy_cycles - b0), 32'(FrameClks));

    // Back-to-back: second byte accepted mid-frame, no gap between frames.
    b0 = busy_cycles;
    send(8'h55);
    run(200);
    check("b2b_ready_mid", 32'(ready), 32'd1);
    send(8'h0F);
    check("b2b_ready_pend", 32'(ready), 32'd0);
    run(2 * FrameClks);
    check("b2b_busy_len", 32'(busy_cycles - b0), 32'(2 * FrameClks));

    // Flow control: byte waits while CTS# is high, starts 3 clocks after it drops.
    cts_n = 1'b1;
    run(3);
    send(8'h3C);
    run(20);
    check("fc_ready", 32'(ready), 32'd0);
    check("fc_tx_idle", 32'(tx), 32'd1);
    cts_n = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      tick();
      if (tx === 1'b0) begin
        lat  = i;
        seen = 1'b1;
      end
    end
    check("cts_latency", 32'(lat), 32'd3);
    run(300);
    cts_n = 1'b1;
    run(FrameClks);

    // Overwrite guard: 0xFF presented while a byte is pending must be ignored.
    send(8'h81);
    data_in = 8'hFF;
    valid   = 1'b1;
    run(5);
    valid = 1'b0;
    cts_n = 1'b0;
    run(FrameClks + 10);

    // Parity-relevant bytes (odd and even popcount).
    b0 = busy_cycles;
    send(8'h07);
    run(FrameClks + 5);
    send(8'h03);
    run(FrameClks + 5);
    check("par_busy_len", 32'(busy_cycles - b0), 32'(2 * FrameClks));

    // Reset mid-frame with a second byte pending: both are lost.
    send(8'h12);
    run(20);
    send(8'h34);
    run(30);
    check("pre_rst_tx", 32'(tx), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    model_reset();
    run(3);
    reset_n = 1'b1;
    b0 = busy_cycles;
    run(FrameClks + 20);
    check("post_rst_idle", 32'(busy_cycles - b0), 32'd0);

    // Random traffic with random CTS# toggling.
    for (int c = 0; c < 12000; c++) begin
      valid   = ($urandom_range(0, 99) < 4);
      data_in = 8'($urandom);
      if ($urandom_range(0, 999) < 2) cts_n = ~cts_n;
      tick();
    end
    valid = 1'b0;
    cts_n = 1'b0;
    run(2 * FrameClks + 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
